axis_write_ctrl: RTL and testbench

- Sequencer for one AXI write transfer: the address and response side of a stream-to-memory write.
- Accepts one transfer command (start address, length in AXI beats) and configures the write-data block through its cfg handshake.
- Splits the transfer into AXI write-address bursts and tracks the write responses.
- Signals completion, and any error response, back to the register layer.

---
 rtl/axis_write_ctrl.sv | 137 +++++++++++++
 tb/tb_axis_write_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_write_ctrl.sv
// Write-transfer sequencer: configures the write-data block, splits one transfer
// into AXI AW bursts and tracks B responses until the transfer is complete.
module axis_write_ctrl #(
    parameter int CFG_DWIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int WIDTH_RATIO    = 2,
    parameter int OUT_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_DWIDTH-1:0]     cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [CFG_DWIDTH-1:0]     data_cfg_length,
    output logic                      data_cfg_valid,
    input  logic                      data_cfg_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      done,
    output logic                      error
);

    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam logic [CFG_DWIDTH-1:0] MAX_BURST = CFG_DWIDTH'(2 ** AXI_LEN_WIDTH);
    localparam logic [OUT_WIDTH-1:0]  MAX_OUT   = '1;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        CONFIG = 5'b00010,
        ADDR   = 5'b00100,
        RESP   = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CFG_DWIDTH-1:0]   remaining;
    logic [OUT_WIDTH-1:0]    outstanding;
    logic [CFG_DWIDTH-1:0]   burst_beats;
    logic                    cfg_hs;
    logic                    aw_hs;
    logic                    b_hs;
    logic                    issue;

    function automatic logic [CFG_DWIDTH-1:0] burst_size(input logic [CFG_DWIDTH-1:0] rem);
        return (rem > MAX_BURST) ? MAX_BURST : rem;
    endfunction

    // Saturating update: a stray B with nothing outstanding must not wrap to all-ones.
    function automatic logic [OUT_WIDTH-1:0] out_update(input logic [OUT_WIDTH-1:0] cnt,
                                                        input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + OUT_WIDTH'(1);
        if (dec && !inc && (cnt != '0))
            return cnt - OUT_WIDTH'(1);
        return cnt;
    endfunction

    function automatic logic [AXI_ADDR_WIDTH-1:0] addr_step(input logic [AXI_LEN_WIDTH-1:0] len);
        return (AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) * AXI_ADDR_WIDTH'(BEAT_BYTES);
    endfunction

    assign cfg_ready      = (state == IDLE);
    assign data_cfg_valid = (state == CONFIG);
    assign axi_bready     = (state == ADDR) || (state == RESP);
    assign done           = (state == DONE);

    assign cfg_hs      = cfg_valid && cfg_ready;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign b_hs        = axi_bvalid && axi_bready;
    assign burst_beats = CFG_DWIDTH'(axi_awlen) + CFG_DWIDTH'(1);

    // A new burst is launched only from an idle AW channel, so after each accept
    // awvalid spends at least one cycle low. Launching on the config handshake
    // makes the first awvalid coincide with entry into ADDR.
    assign issue = !axi_awvalid && (remaining != '0) && (outstanding < MAX_OUT) &&
                   ((state == ADDR) || ((state == CONFIG) && data_cfg_ready));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cfg_valid) state_next = (cfg_length == '0) ? DONE : CONFIG;
            CONFIG:  if (data_cfg_ready) state_next = ADDR;
            ADDR:    if (aw_hs && (remaining == burst_beats)) state_next = RESP;
            RESP:    if ((outstanding == '0) && !b_hs) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            axi_awvalid <= 1'b0;
            remaining   <= '0;
            outstanding <= '0;
            axi_awaddr  <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= out_update(outstanding, aw_hs, b_hs);

            if (cfg_hs) begin
                error      <= 1'b0;
                remaining  <= cfg_length;
                axi_awaddr <= AXI_ADDR_WIDTH'(cfg_address);
            end else if (b_hs && (axi_bresp != 2'b00)) begin
                error <= 1'b1;
            end

            if (aw_hs) begin
                axi_awvalid <= 1'b0;
                remaining   <= remaining - burst_beats;
                axi_awaddr  <= axi_awaddr + addr_step(axi_awlen);
            end else if (issue) begin
                axi_awvalid <= 1'b1;
            end
        end
    end

    // Payload registers: only loaded on their qualifying event, no reset needed.
    always_ff @(posedge clk) begin
        if (cfg_hs)
            data_cfg_length <= cfg_length * CFG_DWIDTH'(WIDTH_RATIO);
        if (issue)
            axi_awlen <= AXI_LEN_WIDTH'(burst_size(remaining) - CFG_DWIDTH'(1));
    end

endmodule

// File: tb/tb_axis_write_ctrl.sv
// Scoreboard bench for axis_write_ctrl: randomized commands and ready/response
// timing checked against a burst-splitting reference model.
module tb_axis_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_address = '0;
    logic [31:0] cfg_length = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] data_cfg_length;
    logic        data_cfg_valid;
    logic        data_cfg_ready = 1'b1;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic        axi_awvalid;
    logic        axi_awready = 1'b1;
    logic [1:0]  axi_bresp = 2'b00;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic        done;
    logic        error;

    axis_write_ctrl #(
        .CFG_DWIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_LEN_WIDTH(8),
        .AXI_DATA_WIDTH(64), .WIDTH_RATIO(2), .OUT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_address(cfg_address), .cfg_length(cfg_length),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .data_cfg_length(data_cfg_length), .data_cfg_valid(data_cfg_valid),
        .data_cfg_ready(data_cfg_ready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_dcfg[$];
    logic [31:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    logic        exp_done[$];
    logic [1:0]  bresp_plan[$];
    logic        exp_err_last;

    int pending_b = 0;
    int aw_acc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    int model_out = 0;
    bit b_en = 1'b1;
    bit aw_force_low = 1'b0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready drivers
    initial forever begin
        @(posedge clk); #1;
        axi_awready    = aw_force_low ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        data_cfg_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // B responder: one response per accepted AW, randomly delayed
    initial begin
        bit bhs;
        forever begin
            @(negedge clk);
            bhs = axi_bvalid && axi_bready && !rst;
            @(posedge clk); #1;
            if (bhs) axi_bvalid = 1'b0;
            if (!axi_bvalid && b_en && pending_b > 0 && $urandom_range(0, 2) != 0) begin
                axi_bvalid = 1'b1;
                pending_b--;
                axi_bresp = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or done
    initial begin
        bit          prev_stall = 0;
        bit          prev_done = 0;
        logic [31:0] prev_addr = '0;
        logic [7:0]  prev_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_done = 0;
            end else begin
                if (prev_stall) begin
                    chk("aw_hold_valid", axi_awvalid, 1);
                    chk("aw_hold_addr", axi_awaddr, prev_addr);
                    chk("aw_hold_len", axi_awlen, prev_len);
                end
                prev_stall = axi_awvalid && !axi_awready;
                prev_addr = axi_awaddr;
                prev_len = axi_awlen;
                if (data_cfg_valid && data_cfg_ready) begin
                    if (exp_dcfg.size() == 0) chk("dcfg_unexpected", 1, 0);
                    else chk("dcfg_length", data_cfg_length, exp_dcfg.pop_front());
                end
                if (axi_awvalid && axi_awready) begin
                    if (exp_aw_addr.size() == 0) chk("aw_unexpected", 1, 0);
                    else begin
                        chk("aw_addr", axi_awaddr, exp_aw_addr.pop_front());
                        chk("aw_len", axi_awlen, exp_aw_len.pop_front());
                    end
                    chk("aw_outstanding_limit", model_out <= 2, 1);
                    aw_acc++;
                    model_out++;
                    pending_b++;
                end
                if (axi_bvalid && axi_bready && model_out > 0) model_out--;
                if (done) begin
                    chk("done_width", prev_done, 0);
                    chk("done_cfg_ready", cfg_ready, 0);
                    chk("done_all_b", model_out, 0);
                    if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                    else chk("done_error", error, exp_done.pop_front());
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_done = done;
            end
        end
    end

    // Reference model: split a transfer into bursts of at most 256 beats
    task automatic plan(input logic [31:0] addr, input int unsigned len,
                        input int err_idx, input bit rand_err);
        logic [31:0] a = addr;
        int unsigned rem = len;
        int unsigned b;
        int i = 0;
        logic [1:0] r;
        logic err = 1'b0;
        if (len != 0) exp_dcfg.push_back(len * 2);
        while (rem > 0) begin
            b = (rem > 256) ? 256 : rem;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(b - 1));
            r = (i == err_idx) ? 2'b10 : ((rand_err && $urandom_range(0, 9) == 0) ? 2'b11 : 2'b00);
            bresp_plan.push_back(r);
            err = err | (r != 2'b00);
            a = a + 32'(b * 8);
            rem = rem - b;
            i++;
        end
        exp_done.push_back(err);
        exp_err_last = err;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] len);
        int n = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_address = addr;
        cfg_length = len;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_ready && n < 50);
        if (!cfg_ready) begin
            chk("cfg_accept_timeout", 0, 1);
            cfg_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("err_cleared_on_accept", error, 0);
        chk("dcfg_valid_latency", data_cfg_valid, len != 0);
        chk("awvalid_after_accept", axi_awvalid, 0);
    endtask

    task automatic wait_done(input int start_cnt);
        int n = 0;
        while (done_cnt == start_cnt && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done_cnt > start_cnt, 1);
        @(negedge clk);
        chk("error_held_idle", error, exp_err_last);
        chk("idle_cfg_ready", cfg_ready, 1);
    endtask

    task automatic run(input logic [31:0] addr, input int unsigned len,
                       input int err_idx, input bit rand_err);
        int s;
        plan(addr, len, err_idx, rand_err);
        s = done_cnt;
        send_cmd(addr, len);
        wait_done(s);
    endtask

    task automatic wait_awvalid();
        int n = 0;
        while (!axi_awvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("awvalid_timeout", axi_awvalid, 1);
    endtask

    initial begin
        int s;
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_data_cfg_valid", data_cfg_valid, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        run(32'h1000, 10, -1, 0);
        run(32'h0, 600, -1, 0);

        // Responses withheld: only three bursts may be outstanding
        b_en = 1'b0;
        plan(32'h0, 1024, -1, 0);
        s = done_cnt;
        base = aw_acc;
        send_cmd(32'h0, 1024);
        n = 0;
        while (aw_acc - base < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("aw_stalled_count", aw_acc - base, 3);
        chk("awvalid_low_when_full", axi_awvalid, 0);
        b_en = 1'b1;
        wait_done(s);

        // awready held low for 5 cycles on the first burst
        aw_force_low = 1'b1;
        plan(32'h8000, 300, -1, 0);
        s = done_cnt;
        send_cmd(32'h8000, 300);
        wait_awvalid();
        repeat (5) @(negedge clk);
        aw_force_low = 1'b0;
        wait_done(s);

        // SLVERR on the second of three responses, then cleared by next command
        run(32'h0, 600, 1, 0);
        run(32'h4000, 10, -1, 0);

        // Zero-length command
        plan(32'h2000, 0, -1, 0);
        s = done_cnt;
        send_cmd(32'h2000, 0);
        wait_done(s);
        chk("zero_len_done_latency", (done_cyc - acc_cyc) <= 1, 1);

        // Address wrap
        run(32'hFFFF_F800, 600, -1, 0);

        // Reset while in ADDR
        b_en = 1'b0;
        aw_force_low = 1'b1;
        plan(32'h0, 600, -1, 0);
        send_cmd(32'h0, 600);
        wait_awvalid();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_awvalid", axi_awvalid, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        chk("midrst_bready", axi_bready, 0);
        rst = 1'b0;
        exp_dcfg.delete();
        exp_aw_addr.delete();
        exp_aw_len.delete();
        exp_done.delete();
        bresp_plan.delete();
        pending_b = 0;
        model_out = 0;
        axi_bvalid = 1'b0;
        aw_force_low = 1'b0;
        b_en = 1'b1;
        run(32'h1000, 10, -1, 0);

        // Randomized commands and handshake timing
        rnd_ready = 1'b1;
        for (int k = 0; k < 10; k++)
            run($urandom & 32'hFFFF_F800, $urandom_range(1, 800), -1, 1);
        rnd_ready = 1'b0;

        repeat (5) @(negedge clk);
        chk("queues_empty", exp_aw_addr.size() + exp_dcfg.size() + exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
